body_sprite_blitter: RTL and testbench

Copies one 16x16, 24-bit sprite tile from a combinational sprite ROM (256 entries, row-major, address = row*16 + col) into the frame buffer at a requested pixel position. It is the reader side of the sprite ROMs: it drives the ROM address, consumes ROM data, and issues ready/valid-style pixel writes to the frame-buffer write port. The game controller requests one tile per snake segment and waits for `o_done`.

---
 rtl/sprite_pkg.sv | 19 +
 rtl/sprite_fb_addr_gen.sv | 28 ++
 rtl/body_sprite_blitter.sv | 130 +++++++++++++
 tb/tb_body_sprite_blitter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite definitions: tile geometry, colour type, default
// transparent key colour and the blitter state encoding.
package sprite_pkg;

    localparam int SPRITE_DIM    = 16;
    localparam int SPRITE_PIXELS = 256;

    typedef logic [23:0] color_t;

    localparam color_t DEFAULT_KEY_COLOR = 24'h181b1d;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } blit_state_t;

endpackage

// File: rtl/sprite_fb_addr_gen.sv
// Combinational frame-buffer address and clip flag for one tile pixel.
// Sums are one bit wider than the tile origin so they cannot wrap
// before the bounds compare.
module sprite_fb_addr_gen #(
    parameter int unsigned FB_WIDTH  = 640,
    parameter int unsigned FB_HEIGHT = 480,
    parameter int unsigned FB_ADDR_W = 19
) (
    input  logic [9:0]           tile_x,
    input  logic [8:0]           tile_y,
    input  logic [3:0]           row,
    input  logic [3:0]           col,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic                 clip
);

    logic [10:0] sum_x;
    logic [9:0]  sum_y;

    // Pixel coordinates, linear address (truncated) and bounds test
    always_comb begin
        sum_x   = {1'b0, tile_x} + {7'b0, col};
        sum_y   = {1'b0, tile_y} + {6'b0, row};
        fb_addr = FB_ADDR_W'(32'(sum_y) * FB_WIDTH + 32'(sum_x));
        clip    = (32'(sum_x) >= FB_WIDTH) || (32'(sum_y) >= FB_HEIGHT);
    end

endmodule

// File: rtl/body_sprite_blitter.sv
// Copies one 16x16 sprite tile from a combinational ROM into the frame
// buffer at (i_tile_x, i_tile_y), clipping pixels outside the buffer.
// Optional macro SPRITE_TRANSPARENCY_EN: pixels equal to KEY_COLOR are
// skipped like clipped pixels instead of being written.
module body_sprite_blitter
    import sprite_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = 640,
    parameter int unsigned FB_HEIGHT = 480,
    parameter int unsigned FB_ADDR_W = 19,
    parameter color_t      KEY_COLOR = DEFAULT_KEY_COLOR
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [9:0]           i_tile_x,
    input  logic [8:0]           i_tile_y,
    output logic [7:0]           o_rom_addr,
    input  logic [23:0]          i_rom_data,
    output logic                 o_fb_we,
    output logic [FB_ADDR_W-1:0] o_fb_addr,
    output logic [23:0]          o_fb_data,
    input  logic                 i_fb_ready,
    output logic                 o_busy,
    output logic                 o_done
);

    blit_state_t          state;
    logic [7:0]           idx;
    logic [9:0]           x_lat;
    logic [8:0]           y_lat;
    logic [FB_ADDR_W-1:0] gen_addr;
    logic                 clip;
    logic                 skip;
    logic                 last;

    sprite_fb_addr_gen #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT),
        .FB_ADDR_W (FB_ADDR_W)
    ) u_addr_gen (
        .tile_x  (x_lat),
        .tile_y  (y_lat),
        .row     (idx[7:4]),
        .col     (idx[3:0]),
        .fb_addr (gen_addr),
        .clip    (clip)
    );

    // The ROM is read combinationally, so it is simply addressed by idx
    assign o_rom_addr = idx;
    assign last       = (idx == 8'(SPRITE_PIXELS - 1));

`ifdef SPRITE_TRANSPARENCY_EN
    // Skip pixels that fall outside the buffer or carry the key colour
    always_comb begin
        skip = clip || (i_rom_data == KEY_COLOR);
    end
`else
    logic unused_key;
    assign unused_key = ^KEY_COLOR;

    // Skip only pixels that fall outside the buffer
    always_comb begin
        skip = clip;
    end
`endif

    // Blit sequencer; all outputs are registered alongside the state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            idx       <= 8'd0;
            x_lat     <= 10'd0;
            y_lat     <= 9'd0;
            o_fb_addr <= '0;
            o_fb_data <= 24'd0;
            o_fb_we   <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        x_lat  <= i_tile_x;
                        y_lat  <= i_tile_y;
                        idx    <= 8'd0;
                        o_busy <= 1'b1;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    o_fb_addr <= gen_addr;
                    o_fb_data <= i_rom_data;
                    if (skip) begin
                        if (last) begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end else begin
                        o_fb_we <= 1'b1;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (i_fb_ready) begin
                        o_fb_we <= 1'b0;
                        if (last) begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_body_sprite_blitter.sv
// Bench for body_sprite_blitter: table of blit scenarios with a write
// scoreboard, plus hand-written spurious-start and mid-blit reset runs.
module tb_body_sprite_blitter;
    import sprite_pkg::*;

    localparam logic [23:0] KEY = 24'h181b1d;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  tile_x;
    logic [8:0]  tile_y;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [23:0] fb_data;
    logic        fb_ready;
    logic        busy;
    logic        done;

    int total;
    int bad;

    typedef struct {
        logic [18:0] addr;
        logic [23:0] data;
    } wr_t;

    typedef struct {
        int x;
        int y;
        int stall;
        int writes;
        int done_cyc;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[5];

    body_sprite_blitter dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_tile_x   (tile_x),
        .i_tile_y   (tile_y),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data),
        .o_fb_we    (fb_we),
        .o_fb_addr  (fb_addr),
        .o_fb_data  (fb_data),
        .i_fb_ready (fb_ready),
        .o_busy     (busy),
        .o_done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Red body sprite: border columns 0-2 and 13-15 are background colour
    function automatic logic [23:0] rom_fn(input logic [7:0] a);
        if (a[3:0] < 4'd3 || a[3:0] > 4'd12) return KEY;
        return {8'hd0, a, 8'h30};
    endfunction

    always_comb rom_data = rom_fn(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic build_expected(input int vx, input int vy);
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            int sx;
            int sy;
            bit skp;
            wr_t w;
            sx  = vx + (i % 16);
            sy  = vy + (i / 16);
            skp = (sx >= 640) || (sy >= 480);
`ifdef SPRITE_TRANSPARENCY_EN
            if (rom_fn(8'(i)) == KEY) skp = 1'b1;
`endif
            if (!skp) begin
                w.addr = 19'(sy * 640 + sx);
                w.data = rom_fn(8'(i));
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic run_blit(input int vx, input int vy, input int stall,
                            input int exp_writes, input int exp_done,
                            input int extra_start, input int rst_at,
                            input bit start_on_done);
        int rel;
        int nwr;
        int stall_cnt;
        int done_at;
        build_expected(vx, vy);
        @(negedge clk);
        tile_x    = 10'(vx);
        tile_y    = 9'(vy);
        start     = 1'b1;
        fb_ready  = 1'b1;
        rel       = 0;
        nwr       = 0;
        stall_cnt = 0;
        done_at   = -1;
        forever begin
            @(negedge clk);
            rel++;
            start = 1'b0;
            if (rst_at >= 0 && rel == rst_at + 1) begin
                check("rst_mid_outs", {7'b0, fb_we, busy, done, fb_addr, fb_data, rom_addr} == '0 ? 32'd0 : 32'd1, 32'd0);
                check("rst_mid_state", 32'(dut.state), 32'(IDLE));
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            if (rel == 1) check("busy_first_fetch", 32'(busy), 32'd1);
            if (done_at >= 0 && rel > done_at) begin
                check("idle_after_done", {29'b0, busy, fb_we, done}, 32'd0);
                if (rel >= done_at + 4) break;
            end
            if (done && done_at < 0) done_at = rel;
            if (fb_we) begin
                if (exp_q.size() == 0) begin
                    check("extra_write_addr", 32'(fb_addr), 32'h7fffffff);
                end else begin
                    check("wr_addr", 32'(fb_addr), 32'(exp_q[0].addr));
                    check("wr_data", 32'(fb_data), 32'(exp_q[0].data));
                end
            end
            fb_ready = 1'b1;
            if (fb_we && nwr == 0 && stall_cnt < stall) begin
                fb_ready = 1'b0;
                stall_cnt++;
            end
            if (fb_we && fb_ready) begin
                nwr++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (rel == extra_start) start = 1'b1;
            if (done && start_on_done) start = 1'b1;
            if (rst_at >= 0 && rel == rst_at) rst = 1'b1;
            if (rel > 1000) begin
                check("timeout_done", 32'(rel), 32'(exp_done));
                break;
            end
        end
        check("done_cycle", 32'(done_at), 32'(exp_done));
        check("write_count", 32'(nwr), 32'(exp_writes));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        tile_x   = 10'd0;
        tile_y   = 9'd0;
        fb_ready = 1'b1;

`ifdef SPRITE_TRANSPARENCY_EN
        vecs[0] = '{x: 16,  y: 32,  stall: 0, writes: 160, done_cyc: 417};
        vecs[1] = '{x: 632, y: 0,   stall: 0, writes: 80,  done_cyc: 337};
        vecs[2] = '{x: 16,  y: 32,  stall: 3, writes: 160, done_cyc: 420};
        vecs[3] = '{x: 630, y: 470, stall: 0, writes: 70,  done_cyc: 327};
        vecs[4] = '{x: 0,   y: 0,   stall: 0, writes: 160, done_cyc: 417};
`else
        vecs[0] = '{x: 16,  y: 32,  stall: 0, writes: 256, done_cyc: 513};
        vecs[1] = '{x: 632, y: 0,   stall: 0, writes: 128, done_cyc: 385};
        vecs[2] = '{x: 16,  y: 32,  stall: 3, writes: 256, done_cyc: 516};
        vecs[3] = '{x: 630, y: 470, stall: 0, writes: 100, done_cyc: 357};
        vecs[4] = '{x: 0,   y: 0,   stall: 0, writes: 256, done_cyc: 513};
`endif

        repeat (3) @(negedge clk);
        check("rst_we", 32'(fb_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_data", 32'(fb_data), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            run_blit(vecs[v].x, vecs[v].y, vecs[v].stall, vecs[v].writes,
                     vecs[v].done_cyc, -1, -1, 1'b0);
        end

        // Starts during FETCH/WRITE and during DONE must not launch a blit
        run_blit(16, 32, 0, vecs[0].writes, vecs[0].done_cyc, 100, -1, 1'b1);

        // Reset in cycle 50, idle in 52, fresh start in 53
        run_blit(16, 32, 0, vecs[0].writes, vecs[0].done_cyc, -1, 50, 1'b0);
        @(negedge clk);
        check("post_rst_idle_busy", 32'(busy), 32'd0);
        run_blit(16, 32, 0, vecs[0].writes, vecs[0].done_cyc, -1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
